mmio_fabric: RTL

- Parametrised memory-mapped interconnect between the CPU data port and N peripherals.
- Replaces a fixed combinational address decode / read mux.
- Adds decode by programmable region nibble/mask, a per-slave ready handshake (wait states), a registered response, and a bus-error path: decode miss or slave timeout, with captured error address and a sticky interrupt.

---
 rtl/mmio_fabric.sv | 91 +++++++++
 1 files changed

// File: rtl/mmio_fabric.sv
// mmio_fabric: region-decoded MMIO interconnect with wait states, slave timeout and bus-error capture
module mmio_fabric #(
  parameter int NUM_SLAVES = 9,
  parameter logic [4*NUM_SLAVES-1:0] SLAVE_BASE = '0,
  parameter logic [4*NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{4'hE}},
  parameter int TIMEOUT = 64,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [3:0]               req_wstrb,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic [NUM_SLAVES-1:0]    s_sel,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic                     err_clear,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count,
  output logic                     irq_err
);
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, nxt;
  logic [IW-1:0] tgt, idx;
  logic [31:0] cnt;
  logic hit, rdy, to, err_ev;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (((req_addr[31:28] ^ SLAVE_BASE[4*i +: 4]) & SLAVE_MASK[4*i +: 4]) == 4'h0) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
  assign rdy = s_ready[tgt];
  assign to = cnt == 32'(TIMEOUT - 1);
  assign err_ev = (state == IDLE && req_valid && !hit) || (state == ACCESS && !rdy && to);
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign s_sel = state == ACCESS ? NUM_SLAVES'(1) << tgt : '0;
  always_comb begin
    nxt = state == IDLE   ? (req_valid ? (hit ? ACCESS : RESP) : IDLE) :
          state == ACCESS ? (rdy || to ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tgt <= '0;
      cnt <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      s_addr <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      err_addr <= '0;
      err_count <= '0;
      irq_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        s_addr <= req_addr;
        s_wdata <= req_wdata;
        s_wstrb <= req_wstrb;
        tgt <= idx;
        cnt <= '0;
      end
      if (state == ACCESS && !rdy) cnt <= cnt + 32'd1;
      if (state == ACCESS && rdy) begin
        resp_rdata <= s_rdata[32*tgt +: 32];
        resp_err <= 1'b0;
      end
      if (err_ev) begin
        resp_rdata <= ERR_RDATA;
        resp_err <= 1'b1;
        err_addr <= state == IDLE ? req_addr : s_addr;
        err_count <= err_count + {7'd0, err_count != 8'hFF};
      end
      irq_err <= err_ev | (irq_err & ~err_clear);
    end
  end
endmodule
